// File: rtl/testport_pkg.sv
// Shared types and constants for the simulation test port writer and its checker.
package testport_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_BEGIN,
    GAP,
    W_DATA,
    W_END,
    DONE
  } state_t;

  localparam logic [29:0] DEFAULT_TEST_PORT    = 30'h10;
  localparam logic [31:0] DEFAULT_BEGIN_SYMBOL = 32'h0000_0168;
  localparam logic [31:0] DEFAULT_END_SYMBOL   = 32'hFFFF_FD5D;

  // Readable (big-endian) word to little-endian bus order.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/tp_sync_fifo.sv
// Small synchronous FIFO with first-word head output and same-cycle push/pop.
module tp_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; a flush only clears the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/testport_writer.sv
// Test port transmitter: begin symbol, RESULT_NUM buffered result words, end symbol,
// each as a byte-swapped store separated by a wen-low gap.
module testport_writer
  import testport_pkg::*;
#(
  parameter logic [29:0] TEST_PORT    = DEFAULT_TEST_PORT,
  parameter logic [31:0] BEGIN_SYMBOL = DEFAULT_BEGIN_SYMBOL,
  parameter logic [31:0] END_SYMBOL   = DEFAULT_END_SYMBOL,
  parameter int unsigned RESULT_NUM   = 18,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        mem_stall,
  output logic [29:0] addr,
  output logic [31:0] data,
  output logic        wen,
  output logic        busy,
  output logic        done
);

  localparam int unsigned SW = $clog2(RESULT_NUM + 1);

  state_t        state;
  logic [SW-1:0] sent;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   fifo_head;
  logic          pop;

  assign in_ready = !fifo_full;
  assign pop      = (state == W_DATA) && !mem_stall;

  tp_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .din   (in_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Sequencer; every store is held until an edge with mem_stall low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sent  <= '0;
      addr  <= '0;
      data  <= '0;
      wen   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= W_BEGIN;
            wen   <= 1'b1;
            addr  <= TEST_PORT;
            data  <= byte_swap(BEGIN_SYMBOL);
            busy  <= 1'b1;
          end
        end
        W_BEGIN, W_DATA, W_END: begin
          if (!mem_stall) begin
            wen  <= 1'b0;
            addr <= '0;
            data <= '0;
            if (state == W_DATA) sent <= sent + SW'(1);
            if (state == W_END) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (sent == SW'(RESULT_NUM)) begin
            state <= W_END;
            wen   <= 1'b1;
            addr  <= TEST_PORT;
            data  <= byte_swap(END_SYMBOL);
          end else if (!fifo_empty) begin
            state <= W_DATA;
            wen   <= 1'b1;
            addr  <= TEST_PORT;
            data  <= byte_swap(fifo_head);
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_testport_writer.sv
// Self-checking bench for testport_writer against a store-list reference model.
module tb_testport_writer;

  localparam int unsigned RN   = 18;
  localparam int unsigned NST  = RN + 2;
  localparam logic [29:0] TP   = 30'h10;
  localparam logic [31:0] BEG  = 32'h0000_0168;
  localparam logic [31:0] ENDS = 32'hFFFF_FD5D;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_stall;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        busy;
  logic        done;

  int tests_run = 0;
  int fails     = 0;

  logic [31:0] feed_q[$];
  logic [31:0] exp_q[$];
  bit          prod_stop = 1'b0;

  // Monitor state
  logic [31:0] acc_q[$];
  int          gap_q[$];
  int          hi_q[$];
  int          rise_cnt = 0;
  int          bad_addr = 0;
  int          bad_hold = 0;
  int          bad_idle = 0;

  testport_writer #(
    .TEST_PORT    (TP),
    .BEGIN_SYMBOL (BEG),
    .END_SYMBOL   (ENDS),
    .RESULT_NUM   (RN),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_stall (mem_stall),
    .addr      (addr),
    .data      (data),
    .wen       (wen),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] swap_ref(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
    return r;
  endfunction

  // Port-side monitor: inputs change just after posedge, so negedge values hold for the next edge.
  initial begin
    logic        pw;
    logic [31:0] pd;
    int          hi;
    int          lo;
    pw = 1'b0; pd = '0; hi = 0; lo = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pw = 1'b0; hi = 0; lo = 0;
      end else begin
        if (wen) begin
          if (addr !== TP) bad_addr++;
          if (!pw) begin
            rise_cnt++;
            gap_q.push_back(lo);
            hi = 0;
          end else if (data !== pd) begin
            bad_hold++;
          end
          hi++;
          if (!mem_stall) begin
            acc_q.push_back(data);
            hi_q.push_back(hi);
          end
          lo = 0;
        end else begin
          if (addr !== '0 || data !== '0) bad_idle++;
          lo++;
        end
        pw = wen;
        pd = data;
      end
    end
  end

  task automatic make_words(input bit fixed_head);
    feed_q = {};
    for (int i = 0; i < RN; i++) feed_q.push_back($urandom);
    if (fixed_head) begin
      feed_q[0] = 32'h0000_DEAD;
      feed_q[1] = 32'h0000_F620;
    end
    exp_q = {};
    exp_q.push_back(swap_ref(BEG));
    for (int i = 0; i < RN; i++) exp_q.push_back(swap_ref(feed_q[i]));
    exp_q.push_back(swap_ref(ENDS));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; mem_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Producer: offers feed_q[from..] whenever the FIFO has room.
  task automatic feed(input int from);
    int   idx;
    int   guard;
    logic r;
    idx = from; guard = 0;
    while (idx < feed_q.size() && !prod_stop && guard < 3000) begin
      in_valid = 1'b1;
      in_data  = feed_q[idx];
      @(negedge clk) r = in_ready;
      @(posedge clk); #1;
      if (r) idx++;
      guard++;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_rise(input int nth, output bit ok);
    int   seen;
    int   g;
    logic pw;
    seen = 0; g = 0; pw = 1'b0; ok = 1'b0;
    while (g < 300) begin
      if (wen && !pw) seen++;
      pw = wen;
      if (seen == nth) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      g++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; mem_stall = 1'b0;
    #1;
    tests_run++;
    if ({wen, busy, done} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: wen/busy/done=%b want 000", {wen, busy, done});
    end
    tests_run++;
    if (addr !== '0 || data !== '0) begin
      fails++; $display("FAIL reset_bus: addr=%h data=%h want 0", addr, data);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_prefill_run();
    int base, gbase, hbase, rbase, abase, n;
    do_reset();
    make_words(1'b1);
    fork feed(0); join_none
    repeat (6) @(posedge clk);
    #1;
    base = acc_q.size(); gbase = gap_q.size(); hbase = hi_q.size();
    rbase = rise_cnt; abase = bad_addr + bad_idle + bad_hold;
    pulse_start();
    wait_done(n);
    // Last store is accepted on the 39th edge after the start-sampling edge (cycle 40 of the run).
    tests_run++;
    if (n != 2 * NST - 1) begin
      fails++; $display("FAIL prefill_done_latency: %0d edges want %0d", n, 2 * NST - 1);
    end
    tests_run++;
    if (acc_q.size() - base != NST || rise_cnt - rbase != NST) begin
      fails++; $display("FAIL prefill_store_count: acc=%0d rise=%0d want %0d",
                        acc_q.size() - base, rise_cnt - rbase, NST);
    end
    for (int i = 0; i < NST && base + i < acc_q.size(); i++) begin
      tests_run++;
      if (acc_q[base + i] !== exp_q[i]) begin
        fails++; $display("FAIL prefill_store[%0d]: got %h want %h", i, acc_q[base + i], exp_q[i]);
      end
    end
    tests_run++;
    if (acc_q.size() >= base + NST &&
        (acc_q[base] !== 32'h6801_0000 || acc_q[base + 1] !== 32'hADDE_0000 ||
         acc_q[base + 2] !== 32'h20F6_0000 || acc_q[base + NST - 1] !== 32'h5DFD_FFFF)) begin
      fails++; $display("FAIL prefill_literals: %h %h %h %h", acc_q[base], acc_q[base + 1],
                        acc_q[base + 2], acc_q[base + NST - 1]);
    end
    for (int i = 1; i < NST && gbase + i < gap_q.size(); i++) begin
      tests_run++;
      if (gap_q[gbase + i] != 1 || hi_q[hbase + i] != 1) begin
        fails++; $display("FAIL prefill_gap[%0d]: low=%0d high=%0d want 1/1", i,
                          gap_q[gbase + i], hi_q[hbase + i]);
      end
    end
    tests_run++;
    if (bad_addr + bad_idle + bad_hold != abase) begin
      fails++; $display("FAIL prefill_bus: addr/idle/hold errors=%0d want 0",
                        bad_addr + bad_idle + bad_hold - abase);
    end
    // Further start pulses in DONE must be ignored.
    rbase = rise_cnt;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if ({done, busy, wen} !== 3'b100 || rise_cnt != rbase) begin
      fails++; $display("FAIL done_sticky: done/busy/wen=%b new stores=%0d want 100/0",
                        {done, busy, wen}, rise_cnt - rbase);
    end
  endtask

  task automatic test_stall();
    int base, hbase, hold0, n;
    bit ok;
    do_reset();
    make_words(1'b0);
    fork feed(0); join_none
    repeat (6) @(posedge clk);
    #1;
    base = acc_q.size(); hbase = hi_q.size(); hold0 = bad_hold;
    pulse_start();
    wait_rise(3, ok);
    mem_stall = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (wen !== 1'b1 || data !== exp_q[2]) begin
      fails++; $display("FAIL stall_hold: wen=%b data=%h want 1/%h", wen, data, exp_q[2]);
    end
    mem_stall = 1'b0;
    wait_done(n);
    tests_run++;
    if (!ok || hi_q.size() < hbase + NST || hi_q[hbase + 2] != 6) begin
      fails++; $display("FAIL stall_length: found=%0d stores=%0d want 6-cycle 3rd store",
                        ok, hi_q.size() - hbase);
    end
    tests_run++;
    if (bad_hold != hold0) begin
      fails++; $display("FAIL stall_stable: data changed %0d times want 0", bad_hold - hold0);
    end
    tests_run++;
    if (acc_q.size() - base != NST) begin
      fails++; $display("FAIL stall_count: got %0d stores want %0d", acc_q.size() - base, NST);
    end
    for (int i = 0; i < NST && base + i < acc_q.size(); i++) begin
      tests_run++;
      if (acc_q[base + i] !== exp_q[i]) begin
        fails++; $display("FAIL stall_store[%0d]: got %h want %h", i, acc_q[base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_slow_feed();
    int base, n;
    do_reset();
    make_words(1'b0);
    base = acc_q.size();
    pulse_start();
    for (int k = 0; k < RN; k++) begin
      repeat (7) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = feed_q[k];
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests_run++;
      if (wen !== 1'b0) begin
        fails++; $display("FAIL slow_gap[%0d]: wen=%b want 0 while push not yet visible", k, wen);
      end
      @(posedge clk); #1;
      tests_run++;
      if (wen !== 1'b1 || data !== exp_q[k + 1]) begin
        fails++; $display("FAIL slow_issue[%0d]: wen=%b data=%h want 1/%h", k, wen, data, exp_q[k + 1]);
      end
    end
    wait_done(n);
    tests_run++;
    if (done !== 1'b1 || acc_q.size() - base != NST) begin
      fails++; $display("FAIL slow_total: done=%b stores=%0d want 1/%0d", done, acc_q.size() - base, NST);
    end
    for (int i = 0; i < NST && base + i < acc_q.size(); i++) begin
      tests_run++;
      if (acc_q[base + i] !== exp_q[i]) begin
        fails++; $display("FAIL slow_store[%0d]: got %h want %h", i, acc_q[base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    int   idx, m, base, n;
    logic r;
    do_reset();
    make_words(1'b0);
    base = acc_q.size();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = feed_q[idx];
      @(negedge clk) r = in_ready;
      @(posedge clk); #1;
      if (r) idx++;
    end
    tests_run++;
    if (idx != 4 || in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_full: accepted=%0d in_ready=%b want 4/0", idx, in_ready);
    end
    // Start while word 4 is still offered; the pop edge must not admit it.
    start   = 1'b1;
    in_data = feed_q[idx];
    @(negedge clk) r = in_ready;
    @(posedge clk); #1;
    start = 1'b0;
    if (r) idx++;
    m = 0;
    while (in_ready !== 1'b1 && m < 20) begin
      @(negedge clk) r = in_ready;
      @(posedge clk); #1;
      if (r) idx++;
      m++;
    end
    tests_run++;
    if (m != 3 || idx != 4) begin
      fails++; $display("FAIL bp_pop_edge: ready after %0d edges accepted=%0d want 3/4", m, idx);
    end
    @(negedge clk) r = in_ready;
    @(posedge clk); #1;
    if (r) idx++;
    tests_run++;
    if (idx != 5 || in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_retry: accepted=%0d in_ready=%b want 5/0", idx, in_ready);
    end
    feed(idx);
    wait_done(n);
    tests_run++;
    if (acc_q.size() - base != NST) begin
      fails++; $display("FAIL bp_count: got %0d stores want %0d", acc_q.size() - base, NST);
    end
    for (int i = 0; i < NST && base + i < acc_q.size(); i++) begin
      tests_run++;
      if (acc_q[base + i] !== exp_q[i]) begin
        fails++; $display("FAIL bp_store[%0d]: got %h want %h", i, acc_q[base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, n;
    bit ok;
    do_reset();
    make_words(1'b0);
    fork feed(0); join_none
    repeat (6) @(posedge clk);
    #1;
    pulse_start();
    wait_rise(9, ok);
    tests_run++;
    if (!ok || wen !== 1'b1) begin
      fails++; $display("FAIL mid_reach9: found=%0d wen=%b want 1/1", ok, wen);
    end
    prod_stop = 1'b1;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({wen, busy, done} !== 3'b000 || addr !== '0 || data !== '0) begin
      fails++; $display("FAIL mid_reset_out: wen/busy/done=%b addr=%h data=%h want 0",
                        {wen, busy, done}, addr, data);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset_flush: in_ready=%b want 1", in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    prod_stop = 1'b0;
    make_words(1'b0);
    base = acc_q.size();
    fork feed(0); join_none
    repeat (6) @(posedge clk);
    #1;
    pulse_start();
    wait_done(n);
    tests_run++;
    if (acc_q.size() - base != NST) begin
      fails++; $display("FAIL mid_rerun_count: got %0d stores want %0d", acc_q.size() - base, NST);
    end
    for (int i = 0; i < NST && base + i < acc_q.size(); i++) begin
      tests_run++;
      if (acc_q[base + i] !== exp_q[i]) begin
        fails++; $display("FAIL mid_rerun_store[%0d]: got %h want %h", i, acc_q[base + i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_prefill_run();
    test_stall();
    test_slow_feed();
    test_back_pressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
